// File: rtl/wb_write_port.sv
// rtl/wb_write_port.sv - register-file write port: loads win, ALU results queue in a FIFO.
// Optional decode-stage forwarding lookup is built only when WB_FORWARD_EN is defined.
module wb_write_port #(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_alu_valid,
  output logic                             out_alu_ready,
  input  logic [REG_INDEX_BITS-1:0]        in_alu_reg_index,
  input  logic [THREAD_INDEX_BITS-1:0]     in_alu_thread_index,
  input  logic [DATA_WIDTH-1:0]            in_alu_data,
  input  logic                             in_load_valid,
  input  logic [REG_INDEX_BITS-1:0]        in_load_reg_index,
  input  logic [THREAD_INDEX_BITS-1:0]     in_load_thread_index,
  input  logic [DATA_WIDTH-1:0]            in_load_data,
  output logic                             out_wr_en,
  output logic [REG_INDEX_BITS-1:0]        out_wr_reg_index,
  output logic [THREAD_INDEX_BITS-1:0]     out_wr_thread_index,
  output logic [DATA_WIDTH-1:0]            out_wr_data,
  output logic [$clog2(FIFO_DEPTH):0]      out_fifo_count,
  input  logic [REG_INDEX_BITS-1:0]        in_fwd_reg_index,
  input  logic [THREAD_INDEX_BITS-1:0]     in_fwd_thread_index,
  output logic                             out_fwd_hit,
  output logic [DATA_WIDTH-1:0]            out_fwd_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [REG_INDEX_BITS-1:0]    fifo_reg  [FIFO_DEPTH];
  logic [THREAD_INDEX_BITS-1:0] fifo_thr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]        fifo_data [FIFO_DEPTH];
  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                wr_ptr;
  logic [CW-1:0]                count;
  logic                         push;
  logic                         pop;

  assign out_fifo_count = count;
  // Ready looks only at occupancy, so a full buffer refuses even while it drains.
  assign out_alu_ready  = (count < DEPTH_C);
  assign push = !reset && in_alu_valid && out_alu_ready;
  assign pop  = !reset && !in_load_valid && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= in_alu_reg_index;
      fifo_thr[wr_ptr]  <= in_alu_thread_index;
      fifo_data[wr_ptr] <= in_alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr              <= '0;
      wr_ptr              <= '0;
      count               <= '0;
      out_wr_en           <= 1'b0;
      out_wr_reg_index    <= '0;
      out_wr_thread_index <= '0;
      out_wr_data         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (in_load_valid) begin
        out_wr_en           <= 1'b1;
        out_wr_reg_index    <= in_load_reg_index;
        out_wr_thread_index <= in_load_thread_index;
        out_wr_data         <= in_load_data;
      end else if (count != '0) begin
        out_wr_en           <= 1'b1;
        out_wr_reg_index    <= fifo_reg[rd_ptr];
        out_wr_thread_index <= fifo_thr[rd_ptr];
        out_wr_data         <= fifo_data[rd_ptr];
      end else begin
        out_wr_en <= 1'b0;
      end
    end
  end

`ifdef WB_FORWARD_EN
  logic [PW-1:0] fwd_idx;

  // Walk oldest to newest so the youngest matching entry wins; the pending write is oldest of all.
  always_comb begin
    out_fwd_hit  = 1'b0;
    out_fwd_data = '0;
    fwd_idx      = rd_ptr;
    if (out_wr_en && out_wr_thread_index == in_fwd_thread_index &&
        out_wr_reg_index == in_fwd_reg_index) begin
      out_fwd_hit  = 1'b1;
      out_fwd_data = out_wr_data;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if (CW'(i) < count && fifo_thr[fwd_idx] == in_fwd_thread_index &&
          fifo_reg[fwd_idx] == in_fwd_reg_index) begin
        out_fwd_hit  = 1'b1;
        out_fwd_data = fifo_data[fwd_idx];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd   = ^{in_fwd_reg_index, in_fwd_thread_index};
  assign out_fwd_hit  = 1'b0;
  assign out_fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// tb/tb_wb_write_port.sv - directed and randomized checks of wb_write_port against a queue model.
module tb_wb_write_port;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0]  thr;
    logic [4:0]  rg;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_v, load_v;
  logic [4:0]  alu_r, load_r, fwd_r;
  logic [2:0]  alu_t, load_t, fwd_t;
  logic [63:0] alu_d, load_d;
  logic        out_alu_ready, out_wr_en, out_fwd_hit;
  logic [4:0]  out_wr_reg_index;
  logic [2:0]  out_wr_thread_index;
  logic [63:0] out_wr_data, out_fwd_data;
  logic [2:0]  out_fifo_count;

  ent_t q[$];
  logic exp_en;
  ent_t exp_wr;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_write_port #(
    .DATA_WIDTH(64), .REG_INDEX_BITS(5), .THREAD_INDEX_BITS(3), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_alu_valid(alu_v), .out_alu_ready(out_alu_ready),
    .in_alu_reg_index(alu_r), .in_alu_thread_index(alu_t), .in_alu_data(alu_d),
    .in_load_valid(load_v), .in_load_reg_index(load_r),
    .in_load_thread_index(load_t), .in_load_data(load_d),
    .out_wr_en(out_wr_en), .out_wr_reg_index(out_wr_reg_index),
    .out_wr_thread_index(out_wr_thread_index), .out_wr_data(out_wr_data),
    .out_fifo_count(out_fifo_count),
    .in_fwd_reg_index(fwd_r), .in_fwd_thread_index(fwd_t),
    .out_fwd_hit(out_fwd_hit), .out_fwd_data(out_fwd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 1'b0; alu_v = 1'b0; load_v = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    int          sz;
    logic        hit_e;
    logic [63:0] fd_e;
    #1;
    sz = q.size();
    check("count", 64'(out_fifo_count), 64'(sz));
    check("ready", 64'(out_alu_ready), 64'(sz < DEPTH));
    hit_e = 1'b0;
    fd_e  = '0;
`ifdef WB_FORWARD_EN
    if (exp_en && exp_wr.thr == fwd_t && exp_wr.rg == fwd_r) begin
      hit_e = 1'b1; fd_e = exp_wr.data;
    end
    foreach (q[i]) if (q[i].thr == fwd_t && q[i].rg == fwd_r) begin
      hit_e = 1'b1; fd_e = q[i].data;
    end
`endif
    check("fwd_hit", 64'(out_fwd_hit), 64'(hit_e));
    check("fwd_data", out_fwd_data, fd_e);
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_en = 1'b0;
      exp_wr = '0;
    end else begin
      if (load_v) begin
        exp_en = 1'b1;
        exp_wr = '{thr: load_t, rg: load_r, data: load_d};
      end else if (q.size() > 0) begin
        exp_en = 1'b1;
        exp_wr = q.pop_front();
      end else begin
        exp_en = 1'b0;
      end
      if (alu_v && sz < DEPTH) q.push_back('{thr: alu_t, rg: alu_r, data: alu_d});
    end
    @(negedge clk);
    check("wr_en", 64'(out_wr_en), 64'(exp_en));
    check("wr_thr", 64'(out_wr_thread_index), 64'(exp_wr.thr));
    check("wr_reg", 64'(out_wr_reg_index), 64'(exp_wr.rg));
    check("wr_data", out_wr_data, exp_wr.data);
  endtask

  task automatic set_alu(input logic [2:0] t, input logic [4:0] r, input logic [63:0] d);
    alu_v = 1'b1; alu_t = t; alu_r = r; alu_d = d;
  endtask

  task automatic set_load(input logic [2:0] t, input logic [4:0] r, input logic [63:0] d);
    load_v = 1'b1; load_t = t; load_r = r; load_d = d;
  endtask

  initial begin
    int exp_cnt[5] = '{2, 2, 2, 1, 0};
    reset = 1'b1; alu_v = 1'b0; load_v = 1'b0;
    alu_r = '0; alu_t = '0; alu_d = '0; load_r = '0; load_t = '0; load_d = '0;
    fwd_r = '0; fwd_t = '0;
    exp_en = 1'b0; exp_wr = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; alu_v = 1'b1; load_v = 1'b1;
    tick();
    check("rst_ready", 64'(out_alu_ready), 64'd1);

    // single ALU push appears two edges later, then the port goes idle
    idle(); set_alu(3'd2, 5'd7, 64'hABCD);
    tick();
    idle();
    tick();
    check("single_en", 64'(out_wr_en), 64'd1);
    check("single_thr", 64'(out_wr_thread_index), 64'd2);
    check("single_reg", 64'(out_wr_reg_index), 64'd7);
    check("single_data", out_wr_data, 64'hABCD);
    tick();
    check("single_idle", 64'(out_wr_en), 64'd0);

    // loads stall two queued ALU results, which then drain in order
    idle(); set_load(3'd0, 5'd1, 64'hF0); set_alu(3'd3, 5'd5, 64'hAAAA);
    tick();
    set_alu(3'd4, 5'd6, 64'hBBBB);
    tick();
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 3) set_load(3'd1, 5'd2, 64'h1000 + 64'(k));
      tick();
      check("stall_count", 64'(out_fifo_count), 64'(exp_cnt[k]));
      check("stall_en", 64'(out_wr_en), 64'd1);
      check("stall_data", out_wr_data,
            (k < 3) ? 64'h1000 + 64'(k) : (k == 3) ? 64'hAAAA : 64'hBBBB);
    end
    idle();
    tick();

    // fill to full under load pressure; fifth push is held
    for (int k = 0; k < 5; k++) begin
      idle(); set_load(3'd5, 5'd9, 64'h77); set_alu(3'd1, 5'(k), 64'h500 + 64'(k > 3 ? 4 : k));
      tick();
    end
    check("full_count", 64'(out_fifo_count), 64'd4);
    check("full_ready", 64'(out_alu_ready), 64'd0);
    idle(); set_alu(3'd1, 5'd4, 64'h504);
    tick();
    check("popfull_count", 64'(out_fifo_count), 64'd3);
    set_load(3'd5, 5'd9, 64'h78);
    tick();
    check("retry_count", 64'(out_fifo_count), 64'd4);
    for (int k = 1; k < 5; k++) begin
      idle();
      tick();
      check("drain_data", out_wr_data, 64'h500 + 64'(k));
    end
    idle();
    tick();

    // reset discards queued entries and ignores the valids
    for (int k = 0; k < 3; k++) begin
      idle(); set_load(3'd6, 5'd3, 64'h99); set_alu(3'd2, 5'(k), 64'hDEAD0 + 64'(k));
      tick();
    end
    reset = 1'b1; load_v = 1'b1; alu_v = 1'b1;
    tick();
    check("rst_count", 64'(out_fifo_count), 64'd0);
    check("rst_en", 64'(out_wr_en), 64'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      tick();
      check("rst_no_write", 64'(out_wr_en), 64'd0);
    end

    // forwarding: newest of two matching entries wins
    idle(); set_load(3'd7, 5'd31, 64'h1); set_alu(3'd1, 5'd4, 64'h11);
    tick();
    set_alu(3'd1, 5'd4, 64'h22);
    tick();
    alu_v = 1'b0; fwd_t = 3'd1; fwd_r = 5'd4;
    #1;
`ifdef WB_FORWARD_EN
    check("fwd_young_hit", 64'(out_fwd_hit), 64'd1);
    check("fwd_young_data", out_fwd_data, 64'h22);
`else
    check("fwd_off_hit", 64'(out_fwd_hit), 64'd0);
    check("fwd_off_data", out_fwd_data, 64'd0);
`endif
    fwd_t = 3'd0;
    #1;
    check("fwd_miss_hit", 64'(out_fwd_hit), 64'd0);
    check("fwd_miss_data", out_fwd_data, 64'd0);
    @(negedge clk);
    idle();
    repeat (3) tick();

    // randomized traffic with small tag space so forwarding matches are frequent
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(63) == 0);
      alu_v  = ($urandom_range(9) < 6);
      alu_t  = 3'($urandom_range(1));
      alu_r  = 5'($urandom_range(3));
      alu_d  = {$urandom, $urandom};
      load_v = ($urandom_range(9) < 3);
      load_t = 3'($urandom_range(1));
      load_r = 5'($urandom_range(3));
      load_d = {$urandom, $urandom};
      fwd_t  = 3'($urandom_range(1));
      fwd_r  = 5'($urandom_range(3));
      tick();
    end
    idle();
    repeat (DEPTH + 2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_write_port.md
WB_WRITE_PORT -- requirements
Module: wb_write_port

Interface
REQ-001 SHALL have parameters DATA_WIDTH (default 64, register data width), REG_INDEX_BITS (default 5, register index width), THREAD_INDEX_BITS (default 3, thread index width) and FIFO_DEPTH (default 4, ALU result buffer entries, power of two, at least 2).
REQ-002 SHALL have a single clock and a reset, where reset is synchronous and active-high: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have ports in_alu_valid  in  1  ALU result offered; out_alu_ready  out  1  result accepted this cycle.
REQ-004 SHALL have ports in_alu_reg_index  in  REG_INDEX_BITS; in_alu_thread_index  in  THREAD_INDEX_BITS; in_alu_data  in  DATA_WIDTH, which carry the ALU result destination and value.
REQ-005 SHALL have ports in_load_valid  in  1; in_load_reg_index  in  REG_INDEX_BITS; in_load_thread_index  in  THREAD_INDEX_BITS; in_load_data  in  DATA_WIDTH, which carry the memory load return and have no backpressure.
REQ-006 SHALL have ports out_wr_en  out  1; out_wr_reg_index  out  REG_INDEX_BITS; out_wr_thread_index  out  THREAD_INDEX_BITS; out_wr_data  out  DATA_WIDTH, which form the registered register-file write port.
REQ-007 SHALL have port out_fifo_count  out  clog2(FIFO_DEPTH)+1, the current ALU buffer occupancy.
REQ-008 SHALL have ports in_fwd_reg_index  in  REG_INDEX_BITS; in_fwd_thread_index  in  THREAD_INDEX_BITS; out_fwd_hit  out  1; out_fwd_data  out  DATA_WIDTH, which form the decode-stage forwarding lookup.

Function
REQ-009 SHALL set out_alu_ready = (out_fifo_count < FIFO_DEPTH), computed combinationally from the count only; a pop in the same cycle does not raise ready when the buffer is full.
REQ-010 SHALL push the ALU triple into the FIFO at a clock edge when in_alu_valid and out_alu_ready are both high, and SHALL otherwise not push it.
REQ-011 SHALL select one write source per cycle: the load input if in_load_valid is high; else the FIFO head if the FIFO is non-empty; else none.
REQ-012 SHALL register the selected source onto out_wr_* with out_wr_en=1 at the next edge, and SHALL set out_wr_en=0 when no source is selected; out_wr_reg_index, out_wr_thread_index and out_wr_data hold their values when out_wr_en=0.
REQ-013 SHALL pop the FIFO head only when the head is selected; a load present that cycle stalls the FIFO head.
REQ-014 SHALL write ALU results in acceptance order; a result accepted at edge E appears on out_wr_* no earlier than after edge E+1.
REQ-015 SHALL leave out_fifo_count unchanged on a simultaneous push and pop, and SHALL wrap the read/write pointers modulo FIFO_DEPTH.
REQ-016 SHALL make a load always win the port; ordering between a load and an ALU write to the same register is the pipeline's responsibility and is not resolved here.
REQ-017 SHALL never issue more than one register-file write per cycle.

Reset
REQ-018 SHALL, on reset high at an edge, clear out_wr_en, out_wr_reg_index, out_wr_thread_index, out_wr_data, the FIFO pointers and the count to 0, discarding buffered entries.
REQ-019 SHALL ignore in_alu_valid and in_load_valid in any cycle where reset is high, and SHALL hold out_alu_ready=1 in the cycle after reset.

Configuration
REQ-020 SHALL, when macro WB_FORWARD_EN is defined, set out_fwd_hit combinationally high if (in_fwd_thread_index, in_fwd_reg_index) matches any valid FIFO entry or the current out_wr_* while out_wr_en=1.
REQ-021 SHALL, when WB_FORWARD_EN is defined, source out_fwd_data from the youngest match, with newest FIFO entry over older FIFO entries over out_wr_*, and SHALL drive out_fwd_data=0 on a miss.
REQ-022 SHALL, when WB_FORWARD_EN is not defined, keep the forwarding ports but tie out_fwd_hit=0 and out_fwd_data=0, with no comparators synthesised.

Verification
REQ-023 SHALL be verified with: single ALU push (thread 2, reg 7, 0xABCD) with the port idle -> out_wr_en=1, thread 2, reg 7, data 0xABCD two edges later, then out_wr_en=0.
REQ-024 SHALL be verified with: load valid on 3 consecutive cycles while 2 ALU results are queued -> 3 load writes first, then the 2 ALU writes in order, with count going 2,2,2,1,0.
REQ-025 SHALL be verified with: 5 back-to-back ALU pushes at FIFO_DEPTH=4 while loads hold the port -> out_alu_ready=0 after 4 accepts, count=4, and the 5th is held until ready returns.
REQ-026 SHALL be verified with: full FIFO plus simultaneous pop and offered push -> push rejected that cycle, count 3 next cycle, push accepted the following cycle.
REQ-027 SHALL be verified with: reset asserted with 3 entries queued and load valid -> next cycle count=0, out_wr_en=0, and no queued entry is ever written.
REQ-028 SHALL be verified, with WB_FORWARD_EN defined, with: FIFO holding (t1,r4,0x11) then (t1,r4,0x22) and lookup (t1,r4) -> out_fwd_hit=1 and out_fwd_data=0x22; lookup (t0,r4) -> hit=0, data=0.
